// File: rtl/ls1u_bus_sequencer_pkg.sv
// Shared types for the KC-LS1u bus sequencer.
//   state_e    : transaction state machine encoding
//   req_kind_e : kind of the transaction currently owned by the sequencer
//   DefaultTimeout : default watchdog limit in cycles
package ls1u_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIfetch,
    StDread,
    StDwrite,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    ReqFetch,
    ReqLoad,
    ReqStore
  } req_kind_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/ls1u_bus_sequencer_if.sv
// Request/response channel between the bus sequencer and bus_unit.
//   write_through_req : byte-lane write strobes      (master -> slave)
//   read_req          : single read request          (master -> slave)
//   pa                : transaction byte address     (master -> slave)
//   wt_data           : write data, byte duplicated  (master -> slave)
//   line_data         : read data                    (slave -> master)
//   trans_rdy         : transaction done             (slave -> master)
//   bus_error         : transaction failed           (slave -> master)
interface ls1u_bus_sequencer_if #(
  parameter int unsigned ADDR_W = 24
) ();

  logic [1:0]        write_through_req;
  logic              read_req;
  logic [ADDR_W-1:0] pa;
  logic [15:0]       wt_data;
  logic [15:0]       line_data;
  logic              trans_rdy;
  logic              bus_error;

  modport master (
    output write_through_req,
    output read_req,
    output pa,
    output wt_data,
    input  line_data,
    input  trans_rdy,
    input  bus_error
  );

  modport slave (
    input  write_through_req,
    input  read_req,
    input  pa,
    input  wt_data,
    output line_data,
    output trans_rdy,
    output bus_error
  );

endinterface

// File: rtl/ls1u_bus_sequencer_watchdog.sv
// Per-transaction watchdog: saturating cycle counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count (asserted on grant)
//   enable   : count this cycle (asserted while a transaction is busy)
//   expired  : the current busy cycle is the Limit-th one; never fires when Limit is 0
module ls1u_bus_watchdog #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CntW    = (Limit > 1) ? $clog2(Limit) : 1;
  // Limit == 0 wraps here, but expired is masked off in that case.
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (Limit != 0) && enable && (count_q == LastCnt);

endmodule

// File: rtl/ls1u_bus_sequencer.sv
// Cache-less bus sequencer: arbitrates instruction fetches and data accesses onto bus_unit.
//   clk, rst                    : clock, asynchronous active-high reset
//   ifetch_req, iaddr           : fetch request (held until instr_ready), word address
//   instr, instr_ready          : last fetched word, one-cycle completion pulse
//   dread, dwrite, daddr, dwdata: data request (held until dready), byte address, write byte
//   drdata, dready              : last read byte, one-cycle completion pulse
//   *_acc_fault                 : one-cycle fault pulses on bus error or watchdog expiry
//   bus                         : registered request channel to bus_unit
module ls1u_bus_sequencer
  import ls1u_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifetch_req,
  input  logic [22:0]          iaddr,
  output logic [15:0]          instr,
  output logic                 instr_ready,
  input  logic                 dread,
  input  logic                 dwrite,
  input  logic [23:0]          daddr,
  input  logic [7:0]           dwdata,
  output logic [7:0]           drdata,
  output logic                 dready,
  output logic                 ins_acc_fault,
  output logic                 load_acc_fault,
  output logic                 store_acc_fault,
  ls1u_bus_sequencer_if.master bus
);

  state_e            state_q, state_d;
  req_kind_e         kind_q;
  logic              last_data_q;
  logic              lane_q;
  logic [ADDR_W-1:0] pa_q;
  logic [15:0]       wt_data_q;
  logic [15:0]       instr_q;
  logic [7:0]        drdata_q;
  logic              read_req_q;
  logic [1:0]        wtr_q;
  logic              instr_ready_q;
  logic              dready_q;
  logic [2:0]        fault_q;  // {store, load, ins}

  logic data_req, grant_fetch, grant_data, busy, done, fault, expired;

  assign data_req = dread | dwrite;
  assign busy     = (state_q == StIfetch) || (state_q == StDread) || (state_q == StDwrite);

  always_comb begin
    state_d     = state_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state_q)
      StIdle: begin
        // Data normally wins; a fetch pending right after a data grant wins instead.
        if (data_req && !(last_data_q && ifetch_req)) begin
          grant_data = 1'b1;
          state_d    = dwrite ? StDwrite : StDread;
        end else if (ifetch_req) begin
          grant_fetch = 1'b1;
          state_d     = StIfetch;
        end
      end
      StIfetch, StDread, StDwrite: begin
        fault = bus.bus_error | expired;
        done  = fault | bus.trans_rdy;
        if (done) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  ls1u_bus_watchdog #(
    .Limit(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_fetch | grant_data),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      kind_q        <= ReqFetch;
      last_data_q   <= 1'b0;
      lane_q        <= 1'b0;
      pa_q          <= '0;
      wt_data_q     <= '0;
      instr_q       <= '0;
      drdata_q      <= '0;
      read_req_q    <= 1'b0;
      wtr_q         <= '0;
      instr_ready_q <= 1'b0;
      dready_q      <= 1'b0;
      fault_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_ready_q <= done && (kind_q == ReqFetch);
      dready_q      <= done && (kind_q != ReqFetch);
      fault_q       <= {fault && (kind_q == ReqStore),
                        fault && (kind_q == ReqLoad),
                        fault && (kind_q == ReqFetch)};
      if (grant_fetch) begin
        kind_q      <= ReqFetch;
        last_data_q <= 1'b0;
        pa_q        <= ADDR_W'({iaddr, 1'b0});
        read_req_q  <= 1'b1;
        wtr_q       <= '0;
      end
      if (grant_data) begin
        kind_q      <= dwrite ? ReqStore : ReqLoad;
        last_data_q <= 1'b1;
        lane_q      <= daddr[0];
        pa_q        <= ADDR_W'(daddr);
        wt_data_q   <= {dwdata, dwdata};
        read_req_q  <= ~dwrite;
        wtr_q       <= dwrite ? {daddr[0], ~daddr[0]} : 2'b00;
      end
      if (done) begin
        read_req_q <= 1'b0;
        wtr_q      <= '0;
        // Return registers only update on a clean completion.
        if (!fault) begin
          if (kind_q == ReqFetch) begin
            instr_q <= bus.line_data;
          end else if (kind_q == ReqLoad) begin
            drdata_q <= lane_q ? bus.line_data[15:8] : bus.line_data[7:0];
          end
        end
      end
    end
  end

  assign instr                 = instr_q;
  assign drdata                = drdata_q;
  assign instr_ready           = instr_ready_q;
  assign dready                = dready_q;
  assign ins_acc_fault         = fault_q[0];
  assign load_acc_fault        = fault_q[1];
  assign store_acc_fault       = fault_q[2];
  assign bus.pa                = pa_q;
  assign bus.wt_data           = wt_data_q;
  assign bus.read_req          = read_req_q;
  assign bus.write_through_req = wtr_q;

endmodule

// File: tb/tb_ls1u_bus_sequencer.sv
module tb_ls1u_bus_sequencer;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_req;
  logic [22:0] iaddr;
  logic [15:0] instr;
  logic        instr_ready;
  logic        dread, dwrite;
  logic [23:0] daddr;
  logic [7:0]  dwdata;
  logic [7:0]  drdata;
  logic        dready;
  logic        ins_acc_fault, load_acc_fault, store_acc_fault;

  ls1u_bus_sequencer_if #(.ADDR_W(24)) bus ();

  ls1u_bus_sequencer #(
    .ADDR_W (24),
    .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifetch_req     (ifetch_req),
    .iaddr          (iaddr),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .dread          (dread),
    .dwrite         (dwrite),
    .daddr          (daddr),
    .dwdata         (dwdata),
    .drdata         (drdata),
    .dready         (dready),
    .ins_acc_fault  (ins_acc_fault),
    .load_acc_fault (load_acc_fault),
    .store_acc_fault(store_acc_fault),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_ir, n_dr, n_flt;

  // Reference model state.
  logic [15:0] m_instr;
  logic [7:0]  m_drdata;
  bit          m_last_data;

  typedef struct {
    logic        rr;
    logic [1:0]  wtr;
    logic [23:0] pa;
    logic [15:0] wtd;
    int          rr_cycles;
    int          resp_cycle;
    logic [2:0]  flt_at_resp;  // {store, load, ins}
    logic        ir_at_resp;
    logic        dr_at_resp;
    logic [15:0] instr;
    logic [7:0]  drdata;
    logic        rr_after;
    logic [1:0]  wtr_after;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pulses();
    if (instr_ready) n_ir++;
    if (dready) n_dr++;
    if (ins_acc_fault || load_acc_fault || store_acc_fault) n_flt++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ifetch_req = 1'b0; dread = 1'b0; dwrite = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0;
    bus.line_data = '0; bus.trans_rdy = 1'b0; bus.bus_error = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_instr = '0; m_drdata = '0; m_last_data = 1'b0;
    tick();
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic drive_req(input int kind, input logic [22:0] ia, input logic [23:0] da,
                           input logic [7:0] wd);
    iaddr = ia; daddr = da; dwdata = wd;
    ifetch_req = (kind == 0);
    dread      = (kind == 1);
    dwrite     = (kind == 2);
  endtask

  // Model: a completed access updates the return register of its kind unless it faulted.
  task automatic model_apply(input int kind, input logic [23:0] a, input logic [15:0] line,
                             input bit faulted);
    if (!faulted) begin
      if (kind == 0) m_instr = line;
      else if (kind == 1) m_drdata = 8'(line >> (8 * a[0]));
    end
    m_last_data = (kind != 0);
  endtask

  // Called in an idle cycle with requests driven. Plays bus_unit: answers in busy cycle lat
  // (0 = never). Returns in the cycle after the response cycle.
  task automatic run_txn(input int lat, input logic [15:0] line, input bit err, input bit rdy,
                         input bit drop, output obs_t o);
    o = '{default: 0};
    o.resp_cycle = -1;
    n_ir = 0; n_dr = 0; n_flt = 0;
    tick();
    o.rr = bus.read_req; o.wtr = bus.write_through_req; o.pa = bus.pa; o.wtd = bus.wt_data;
    for (int c = 1; c <= 40; c++) begin
      if (bus.read_req) o.rr_cycles++;
      sample_pulses();
      if (c == lat) begin
        bus.line_data = line; bus.trans_rdy = rdy; bus.bus_error = err;
      end
      tick();
      bus.trans_rdy = 1'b0; bus.bus_error = 1'b0;
      if (instr_ready || dready) begin
        o.resp_cycle  = c + 1;
        o.flt_at_resp = {store_acc_fault, load_acc_fault, ins_acc_fault};
        o.ir_at_resp  = instr_ready;
        o.dr_at_resp  = dready;
        o.instr       = instr;
        o.drdata      = drdata;
        o.rr_after    = bus.read_req;
        o.wtr_after   = bus.write_through_req;
        sample_pulses();
        if (drop) begin
          ifetch_req = 1'b0; dread = 1'b0; dwrite = 1'b0;
        end
        tick();
        sample_pulses();
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.read_req !== 1'b0) begin failures++; $display("FAIL reset_read_req got=%b exp=0", bus.read_req); end
    checks++; if (bus.write_through_req !== 2'b00) begin failures++; $display("FAIL reset_wtr got=%b exp=00", bus.write_through_req); end
    checks++; if (bus.pa !== 24'h0) begin failures++; $display("FAIL reset_pa got=%h exp=0", bus.pa); end
    checks++; if (bus.wt_data !== 16'h0) begin failures++; $display("FAIL reset_wt_data got=%h exp=0", bus.wt_data); end
    checks++; if (instr !== 16'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
    checks++; if (drdata !== 8'h0) begin failures++; $display("FAIL reset_drdata got=%h exp=0", drdata); end
    checks++;
    if ({instr_ready, dready, ins_acc_fault, load_acc_fault, store_acc_fault} !== 5'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=00000",
                           {instr_ready, dready, ins_acc_fault, load_acc_fault, store_acc_fault});
    end
  endtask

  task automatic test_idle_ignore();
    n_ir = 0; n_dr = 0; n_flt = 0;
    bus.line_data = 16'hDEAD; bus.trans_rdy = 1'b1; bus.bus_error = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample_pulses();
    end
    bus.trans_rdy = 1'b0; bus.bus_error = 1'b0;
    tick();
    sample_pulses();
    checks++; if (n_ir + n_dr + n_flt != 0) begin failures++; $display("FAIL idle_ignore_pulses got=%0d exp=0", n_ir + n_dr + n_flt); end
    checks++; if (instr !== m_instr) begin failures++; $display("FAIL idle_ignore_instr got=%h exp=%h", instr, m_instr); end
  endtask

  task automatic test_fetch();
    obs_t o;
    drive_req(0, 23'h000010, 24'h0, 8'h0);
    run_txn(3, 16'hA55A, 1'b0, 1'b1, 1'b1, o);
    model_apply(0, 24'h0, 16'hA55A, 1'b0);
    checks++; if (o.pa !== 24'h000020) begin failures++; $display("FAIL fetch_pa got=%h exp=000020", o.pa); end
    checks++; if (o.rr_cycles != 3) begin failures++; $display("FAIL fetch_read_req_cycles got=%0d exp=3", o.rr_cycles); end
    checks++; if (o.instr !== m_instr) begin failures++; $display("FAIL fetch_instr got=%h exp=%h", o.instr, m_instr); end
    checks++; if (n_ir != 1 || n_dr != 0) begin failures++; $display("FAIL fetch_ready_pulses got=%0d/%0d exp=1/0", n_ir, n_dr); end
    checks++; if (o.resp_cycle != 4) begin failures++; $display("FAIL fetch_latency got=%0d exp=4", o.resp_cycle); end
    checks++; if (o.rr_after !== 1'b0) begin failures++; $display("FAIL fetch_read_req_drop got=%b exp=0", o.rr_after); end
  endtask

  task automatic test_write_read();
    obs_t o;
    int   lat;
    lat = int'($urandom_range(1, TO - 1));
    drive_req(2, 23'h0, 24'h000101, 8'h3C);
    run_txn(lat, 16'hFFFF, 1'b0, 1'b1, 1'b1, o);
    model_apply(2, 24'h000101, 16'hFFFF, 1'b0);
    checks++; if (o.wtr !== 2'b10) begin failures++; $display("FAIL write_strobe got=%b exp=10", o.wtr); end
    checks++; if (o.wtd !== 16'h3C3C) begin failures++; $display("FAIL write_data got=%h exp=3C3C", o.wtd); end
    checks++; if (o.rr !== 1'b0) begin failures++; $display("FAIL write_read_req got=%b exp=0", o.rr); end
    checks++; if (n_dr != 1 || n_ir != 0) begin failures++; $display("FAIL write_ready_pulses got=%0d/%0d exp=1/0", n_dr, n_ir); end
    drive_req(1, 23'h0, 24'h000101, 8'h00);
    run_txn(lat, 16'h3C00, 1'b0, 1'b1, 1'b1, o);
    model_apply(1, 24'h000101, 16'h3C00, 1'b0);
    checks++; if (o.drdata !== 8'h3C || m_drdata !== 8'h3C) begin failures++; $display("FAIL read_drdata got=%h exp=3C", o.drdata); end
    checks++; if (o.pa !== 24'h000101) begin failures++; $display("FAIL read_pa got=%h exp=000101", o.pa); end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    bit          exp_data;
    logic [23:0] exp_pa;
    apply_reset();
    iaddr = 23'h000200; daddr = 24'h000777; dwdata = 8'h00;
    ifetch_req = 1'b1; dread = 1'b1; dwrite = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_data = !m_last_data;  // both pending: whichever did not go last
      exp_pa   = exp_data ? daddr : {iaddr, 1'b0};
      run_txn(2, 16'h1234 + 16'(t), 1'b0, 1'b1, 1'b0, o);
      model_apply(exp_data ? 1 : 0, daddr, 16'h1234 + 16'(t), 1'b0);
      checks++; if (o.pa !== exp_pa) begin failures++; $display("FAIL arb_grant_%0d got=%h exp=%h", t, o.pa, exp_pa); end
      checks++; if (o.dr_at_resp !== exp_data) begin failures++; $display("FAIL arb_kind_%0d got=%b exp=%b", t, o.dr_at_resp, exp_data); end
      checks++; if (o.resp_cycle != 3) begin failures++; $display("FAIL arb_latency_%0d got=%0d exp=3", t, o.resp_cycle); end
    end
    ifetch_req = 1'b0; dread = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    obs_t o;
    drive_req(1, 23'h0, 24'($urandom), 8'h0);
    run_txn(2, 16'hBEEF, 1'b1, 1'b0, 1'b1, o);
    model_apply(1, daddr, 16'hBEEF, 1'b1);
    checks++; if (o.flt_at_resp !== 3'b010 || o.dr_at_resp !== 1'b1) begin failures++; $display("FAIL load_fault got=%b/%b exp=010/1", o.flt_at_resp, o.dr_at_resp); end
    checks++; if (o.drdata !== m_drdata) begin failures++; $display("FAIL load_fault_drdata got=%h exp=%h", o.drdata, m_drdata); end
    checks++; if (o.rr_after !== 1'b0) begin failures++; $display("FAIL load_fault_drop got=%b exp=0", o.rr_after); end
    drive_req(0, 23'($urandom), 24'h0, 8'h0);
    run_txn(3, 16'hCAFE, 1'b1, 1'b1, 1'b1, o);
    model_apply(0, 24'h0, 16'hCAFE, 1'b1);
    checks++; if (o.flt_at_resp !== 3'b001 || o.ir_at_resp !== 1'b1) begin failures++; $display("FAIL fetch_fault got=%b/%b exp=001/1", o.flt_at_resp, o.ir_at_resp); end
    checks++; if (o.instr !== m_instr) begin failures++; $display("FAIL fetch_fault_instr got=%h exp=%h", o.instr, m_instr); end
    checks++; if (n_flt != 1) begin failures++; $display("FAIL fetch_fault_pulses got=%0d exp=1", n_flt); end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_req(2, 23'h0, 24'h00ABC0, 8'h5A);
    run_txn(0, 16'h0, 1'b0, 1'b0, 1'b1, o);
    model_apply(2, 24'h00ABC0, 16'h0, 1'b1);
    checks++; if (o.resp_cycle != int'(TO) + 1) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", o.resp_cycle, TO + 1); end
    checks++; if (o.flt_at_resp !== 3'b100 || o.dr_at_resp !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b/%b exp=100/1", o.flt_at_resp, o.dr_at_resp); end
    checks++; if (o.wtr !== 2'b01) begin failures++; $display("FAIL timeout_strobe got=%b exp=01", o.wtr); end
    checks++; if (o.wtr_after !== 2'b00) begin failures++; $display("FAIL timeout_strobe_drop got=%b exp=00", o.wtr_after); end
  endtask

  task automatic test_reset_mid();
    obs_t        o;
    logic [15:0] line;
    drive_req(0, 23'h001234, 24'h0, 8'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.read_req !== 1'b0 || bus.pa !== 24'h0) begin failures++; $display("FAIL midreset_bus got=%b/%h exp=0/0", bus.read_req, bus.pa); end
    checks++; if (instr !== 16'h0 || drdata !== 8'h0) begin failures++; $display("FAIL midreset_regs got=%h/%h exp=0/0", instr, drdata); end
    ifetch_req = 1'b0;
    m_instr = '0; m_drdata = '0; m_last_data = 1'b0;
    n_ir = 0; n_dr = 0; n_flt = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sample_pulses();
    end
    checks++; if (n_ir + n_dr + n_flt != 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", n_ir + n_dr + n_flt); end
    line = 16'($urandom);
    drive_req(0, 23'h000777, 24'h0, 8'h0);
    run_txn(2, line, 1'b0, 1'b1, 1'b1, o);
    model_apply(0, 24'h0, line, 1'b0);
    checks++; if (o.instr !== m_instr || n_ir != 1) begin failures++; $display("FAIL midreset_refetch got=%h/%0d exp=%h/1", o.instr, n_ir, m_instr); end
  endtask

  task automatic test_random();
    obs_t        o;
    int          kind, lat;
    bit          err, rdy;
    logic [22:0] ia;
    logic [23:0] da, exp_pa;
    logic [7:0]  wd;
    logic [15:0] line;
    logic [1:0]  exp_wtr;
    logic [2:0]  exp_flt;
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 2));
      ia = 23'($urandom); da = 24'($urandom); wd = 8'($urandom); line = 16'($urandom);
      lat  = int'($urandom_range(1, TO - 1));
      err  = ($urandom_range(0, 3) == 0);
      rdy  = err ? ($urandom_range(0, 1) == 1) : 1'b1;
      exp_pa  = (kind == 0) ? {ia, 1'b0} : da;
      exp_wtr = (kind == 2) ? (2'b01 << da[0]) : 2'b00;
      exp_flt = err ? (3'b001 << kind) : 3'b000;
      drive_req(kind, ia, da, wd);
      run_txn(lat, line, err, rdy, 1'b1, o);
      model_apply(kind, da, line, err);
      checks++; if (o.pa !== exp_pa) begin failures++; $display("FAIL rnd%0d_pa got=%h exp=%h", n, o.pa, exp_pa); end
      checks++; if (o.rr !== (kind != 2) || o.wtr !== exp_wtr) begin failures++; $display("FAIL rnd%0d_req got=%b/%b exp=%b/%b", n, o.rr, o.wtr, kind != 2, exp_wtr); end
      checks++; if (kind == 2 && o.wtd !== {wd, wd}) begin failures++; $display("FAIL rnd%0d_wt_data got=%h exp=%h", n, o.wtd, {wd, wd}); end
      checks++; if (o.resp_cycle != lat + 1) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, o.resp_cycle, lat + 1); end
      checks++; if (o.flt_at_resp !== exp_flt) begin failures++; $display("FAIL rnd%0d_fault got=%b exp=%b", n, o.flt_at_resp, exp_flt); end
      checks++; if (n_ir != (kind == 0 ? 1 : 0) || n_dr != (kind == 0 ? 0 : 1)) begin failures++; $display("FAIL rnd%0d_ready got=%0d/%0d kind=%0d", n, n_ir, n_dr, kind); end
      checks++; if (o.instr !== m_instr || o.drdata !== m_drdata) begin failures++; $display("FAIL rnd%0d_regs got=%h/%h exp=%h/%h", n, o.instr, o.drdata, m_instr, m_drdata); end
      checks++; if (o.rr_after !== 1'b0 || o.wtr_after !== 2'b00) begin failures++; $display("FAIL rnd%0d_drop got=%b/%b exp=0/00", n, o.rr_after, o.wtr_after); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_fetch();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
